// File: rtl/bcd_cvt_arbiter_pkg.sv
// Shared types and helpers for the round-robin BCD converter scheduler.
package bcd_cvt_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int BCD_W_DEF  = 20;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_START    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  // Index width for n requesters; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_cvt_arbiter_if.sv
// Requester and converter signals of the scheduler, grouped for port binding.
interface bcd_cvt_arbiter_if
  import bcd_cvt_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BCD_W  = BCD_W_DEF
);
  localparam int IW = idx_w(N_REQ);

  // Requester side: req_i is a level held until the one-cycle ack_o pulse;
  // done_o/err_o later report the outcome for that same requester.
  // Converter side: cvt_start_o is a one-cycle pulse, cvt_busy_i is the
  // converter's ready-not, and cvt_bcd_i is valid when cvt_busy_i falls.
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        ack_o;
  logic [N_REQ-1:0]        done_o;
  logic [N_REQ-1:0]        err_o;
  logic [BCD_W-1:0]        result_o;
  logic [IW-1:0]           grant_id_o;
  logic                    busy_o;
  logic                    cvt_start_o;
  logic [DATA_W-1:0]       cvt_data_o;
  logic                    cvt_busy_i;
  logic [BCD_W-1:0]        cvt_bcd_i;

  modport master (
    input  req_i, req_data_i, cvt_busy_i, cvt_bcd_i,
    output ack_o, done_o, err_o, result_o, grant_id_o, busy_o,
           cvt_start_o, cvt_data_o
  );

  modport slave (
    output req_i, req_data_i, cvt_busy_i, cvt_bcd_i,
    input  ack_o, done_o, err_o, result_o, grant_id_o, busy_o,
           cvt_start_o, cvt_data_o
  );

endinterface

// File: rtl/bcd_cvt_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module bcd_cvt_arbiter_rr_pick
  import bcd_cvt_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] k;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    sum = '0;
    k   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      k = sum[IW-1:0];
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/bcd_cvt_arbiter.sv
// Round-robin scheduler sharing one iterative binary-to-BCD converter among N_REQ requesters.
module bcd_cvt_arbiter
  import bcd_cvt_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BCD_W   = BCD_W_DEF,
  parameter int TIMEOUT = 64,
  parameter int ACK_TO  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  bcd_cvt_arbiter_if.master bus,
  output state_t            dbg_state
);

  localparam int IW  = idx_w(N_REQ);
  localparam int WDW = $clog2(((TIMEOUT > ACK_TO) ? TIMEOUT : ACK_TO) + 1);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [WDW-1:0]    wd;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  ack_q, done_q, err_q;
  logic              start_q;
  logic [BCD_W-1:0]  result_q;
  logic [DATA_W-1:0] data_q;
  logic [IW-1:0]     gid_q;

  logic [N_REQ-1:0]  pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;

  bcd_cvt_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (bus.req_i),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Pulses are held in their registers while en is low and only shown once en returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      wd       <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      data_q   <= '0;
      gid_q    <= '0;
    end else if (en) begin
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            state  <= S_GRANT;
            gnt_q  <= pick_oh;
            ack_q  <= pick_oh;
            gid_q  <= pick_idx;
            data_q <= bus.req_data_i[pick_idx*DATA_W +: DATA_W];
            ptr    <= (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
          end
        end
        S_GRANT: begin
          state   <= S_START;
          start_q <= 1'b1;
          wd      <= '0;
        end
        S_START: state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (bus.cvt_busy_i) begin
            state <= S_RUN;
            wd    <= '0;
          end else if (wd == WDW'(ACK_TO-1)) begin
            state <= S_ERR;
            err_q <= gnt_q;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RUN: begin
          // Busy falling wins over a timeout expiring in the same cycle.
          if (!bus.cvt_busy_i) begin
            state    <= S_DONE;
            done_q   <= gnt_q;
            result_q <= bus.cvt_bcd_i;
          end else if (wd == WDW'(TIMEOUT-1)) begin
            state <= S_ERR;
            err_q <= gnt_q;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack_o       = ack_q & {N_REQ{en}};
  assign bus.done_o      = done_q & {N_REQ{en}};
  assign bus.err_o       = err_q & {N_REQ{en}};
  assign bus.cvt_start_o = start_q & en;
  assign bus.result_o    = result_q;
  assign bus.grant_id_o  = gid_q;
  assign bus.cvt_data_o  = data_q;
  assign bus.busy_o      = (state != S_IDLE);
  assign dbg_state       = state;

endmodule

// File: doc/bcd_cvt_arbiter.md
Name: bcd_cvt_arbiter

Overview:
- Round-robin scheduler that shares one iterative 16-bit binary-to-BCD converter (start pulse / busy handshake) among N_REQ requesters.
- Each requester is sequenced through grant, capture, start, wait-busy, run and result delivery, with a watchdog against a hung converter.
- Sits between the value producers (counters, sensor readouts) and the single converter instance feeding the 7-segment path.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 16, binary operand width
BCD_W, 20, packed BCD result width (5 digits)
TIMEOUT, 64, max cycles allowed in RUN before error
ACK_TO, 2, max cycles allowed from start to cvt_busy_i rising

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset: one clock; synchronous, active-low
en  in  1  global enable; low freezes FSM and counters
req_i  in  N_REQ  per-requester level request, held until ack_o
req_data_i  in  N_REQ*DATA_W  packed operands, requester k at [k*DATA_W +: DATA_W]
ack_o  out  N_REQ  one-hot 1-cycle pulse: operand captured
done_o  out  N_REQ  one-hot 1-cycle pulse: result_o valid for that requester
err_o  out  N_REQ  one-hot 1-cycle pulse: conversion aborted (timeout)
result_o  out  BCD_W  last result, held until next done/err
grant_id_o  out  clog2(N_REQ)  index of current/last granted requester
busy_o  out  1  high in any state other than IDLE
cvt_start_o  out  1  1-cycle start pulse to converter
cvt_data_o  out  DATA_W  operand to converter, stable from START until the next grant
cvt_busy_i  in  1  converter busy
cvt_bcd_i  in  BCD_W  converter result, valid when cvt_busy_i falls

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, rr pointer=0, all outputs 0, counters 0. Mid-operation reset aborts silently: no done/err pulse. Requesters re-request.
- en=0: state, pointer and counters hold; ack/done/err/cvt_start are forced 0. A pulse due that cycle is deferred until en returns.
- States: IDLE, GRANT, START, WAIT_ACK, RUN, DONE, ERR.
- IDLE: if any req_i, pick the first set bit searching upward from the rr pointer with wrap. Then go to GRANT.
- GRANT: latch operand into cvt_data_o; set grant_id_o; pulse ack_o[g]; set pointer = (g+1) mod N_REQ. Go to START.
- START: cvt_start_o=1 for exactly one cycle; clear watchdog. Go to WAIT_ACK.
- WAIT_ACK: cvt_busy_i=1 goes to RUN. Otherwise increment the counter; after ACK_TO cycles without busy go to ERR.
- RUN: count cycles. If cvt_busy_i=0, capture cvt_bcd_i into result_o and go to DONE. If the count reaches TIMEOUT with busy still high, go to ERR. If both happen in the same cycle, the busy fall wins and goes to DONE.
- DONE: pulse done_o[g]. Go to IDLE, so re-arbitration happens the next cycle.
- ERR: pulse err_o[g]; result_o unchanged. Go to IDLE.
- Latency, no contention, converter busy for C cycles:
  - ack_o at T+1 after req_i is seen in IDLE at T.
  - cvt_start_o at T+2.
  - done_o at T+2+1+C+1 (nominal).
- Minimum gap between two grants is one IDLE cycle.
- req_i deasserted after ack_o: no effect on the running conversion.
- req_i asserted then dropped before grant: ignored if low when sampled in IDLE.
- Simultaneous requests: exactly one is granted per IDLE. Any persistently requesting client waits at most N_REQ-1 conversions.
- The same requester may be granted back-to-back only if no other req_i is set.

Decomposition:
- Shared package holds:
  - the state encoding enum/localparams;
  - DATA_W/BCD_W defaults;
  - a function for the clog2 index width.
- One natural sub-module, rr_pick: combinational round-robin priority picker. Inputs req vector and pointer; outputs one-hot grant and index. It is instantiated once.
- Watchdog counter and FSM live in the top.

Test Plan:
- Single request, data 65233, converter model busy 17 cycles: ack_o=0001, one start pulse, then done_o=0001 and result_o=20'h65233.
- req_i=1111 held, data 1,2,3,4: grants in order 0,1,2,3; results 20'h00001..00004, each with its own done pulse.
- Pointer wrap: after a grant to 2, req_i=1011 → grant 3, then 0, then 1.
- Converter never raises busy: err_o pulses ACK_TO+1 cycles after start; result_o keeps its previous value; the next request is still served.
- Busy stuck high: err_o at TIMEOUT; busy falling on the same cycle as timeout gives done_o, not err_o.
- rst_n low during RUN: no done/err; all outputs 0 on the next cycle. en low for 5 cycles mid-RUN delays done_o by exactly 5 cycles.
